// File: rtl/apply_shift.sv
// Denormaliser: right-shifts a normalised value by its shift code, one bit per clock, flagging lost bits and illegal codes.
// Latency s+2 edges for numeric shift s, 1 edge for special/illegal codes; result holds in DONE until out_ready.
module apply_shift #(
  parameter int WIDTH = 12,
  parameter int SHW   = 5,
  parameter int MAXSH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_val,
  input  logic [SHW-1:0]   in_shift,
  input  logic             in_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_val,
  output logic             out_inexact,
  output logic             out_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [SHW-1:0] SPECIAL_CODE = '1;
  localparam logic [SHW-1:0] MAX_CODE     = SHW'(MAXSH);

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [SHW-1:0]   r_cnt;
  logic             r_inexact;
  logic [WIDTH-1:0] r_out_val;
  logic             r_out_inexact;
  logic             r_out_err;
  logic             r_in_ready;
  logic             r_out_valid;

  logic w_accept;
  logic w_special;
  logic w_legal;

  assign w_accept  = in_valid && r_in_ready;
  assign w_special = (in_shift == SPECIAL_CODE);
  assign w_legal   = (in_shift <= MAX_CODE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_data        <= '0;
      r_cnt         <= '0;
      r_inexact     <= 1'b0;
      r_out_val     <= '0;
      r_out_inexact <= 1'b0;
      r_out_err     <= 1'b0;
      r_in_ready    <= 1'b1;
      r_out_valid   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            if (w_special) begin
              // Special code: zero flag selects 0, otherwise the bit-11 value passes straight through
              r_out_val     <= in_zero ? '0 : in_val;
              r_out_inexact <= 1'b0;
              r_out_err     <= 1'b0;
              r_out_valid   <= 1'b1;
              r_state       <= DONE;
            end else if (w_legal) begin
              r_data    <= in_val;
              r_cnt     <= in_shift;
              r_inexact <= 1'b0;
              r_state   <= SHIFT;
            end else begin
              r_out_val     <= '0;
              r_out_inexact <= 1'b0;
              r_out_err     <= 1'b1;
              r_out_valid   <= 1'b1;
              r_state       <= DONE;
            end
          end
        end
        SHIFT: begin
          if (r_cnt == '0) begin
            r_out_val     <= r_data;
            r_out_inexact <= r_inexact;
            r_out_err     <= 1'b0;
            r_out_valid   <= 1'b1;
            r_state       <= DONE;
          end else begin
            r_data    <= r_data >> 1;
            r_inexact <= r_inexact | r_data[0];
            r_cnt     <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_val     = r_out_val;
  assign out_inexact = r_out_inexact;
  assign out_err     = r_out_err;

endmodule

// File: doc/apply_shift.md
Name: apply_shift

Overview:
- Inverse of the leading-one normaliser: takes a normalised 12-bit value plus its 5-bit shift code and zero flag, and reconstructs the original value by shifting right.
- Iterative: one bit of right shift per clock. Tracks bits lost on the way out (inexact) and flags illegal shift codes.
- Sits on the neuron datapath after the normalised-domain multiply/accumulate, converting results back to the plain 12-bit domain.
- Valid/ready handshake on both input and output sides.

Parameters:
- WIDTH, 12, data width of in_val/out_val.
- SHW, 5, shift-code width; the all-ones code (31) is the special "no shift / zero" code.
- MAXSH, 10, largest legal numeric shift (WIDTH-2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream offers a request.
- in_ready  output  1  block can accept a request (high only in IDLE).
- in_val  input  WIDTH  normalised value (leading one at bit 10, or bit 11 set for the special code).
- in_shift  input  SHW  shift code: 0..10 numeric, 31 special, 11..30 illegal.
- in_zero  input  1  zero flag from the normaliser.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_val  output  WIDTH  reconstructed value.
- out_inexact  output  1  at least one '1' bit was shifted out.
- out_err  output  1  illegal shift code was received.

Behaviour:
- Reset (rst=1 at a clk edge), from any state including mid-shift:
  - state=IDLE; in_ready=1; out_valid=0; out_val=0; out_inexact=0; out_err=0; internal counter=0.
  - Any in-flight request is discarded.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready, the request is captured at the clock edge and classified:
    - in_shift=31 and in_zero=1: result 0, inexact 0, err 0. Go to DONE.
    - in_shift=31 and in_zero=0: result in_val unchanged (bit-11 case), inexact 0, err 0. Go to DONE.
    - in_shift=0..10: in_zero is ignored. Load data=in_val, cnt=in_shift, inexact=0. Go to SHIFT.
    - in_shift=11..30: result 0, inexact 0, err 1. Go to DONE.
  - in_zero=1 with in_shift!=31 is treated as a numeric or illegal code per in_shift.
- SHIFT:
  - in_ready=0, out_valid=0.
  - If cnt==0, go to DONE with data unchanged.
  - Otherwise: data<=data>>1 (logical, zero-fill); inexact<=inexact|data[0]; cnt<=cnt-1.
  - The bit-10 leading-one is not checked; any in_val is shifted as given.
- DONE:
  - out_valid=1, and out_val/out_inexact/out_err are registered and stable.
  - These outputs hold, unchanged, while out_ready=0.
  - On out_valid&&out_ready, return to IDLE next cycle. out_valid drops then. out_val/out_inexact/out_err keep their last values until the next result.
  - in_ready=0 in DONE: no same-cycle accept on completion, so the minimum request spacing is one idle cycle.
- Latency, counted from the accept edge T:
  - Numeric shift s: out_valid first high at edge T+s+2 (1 cycle to load, s shift cycles, 1 cycle for the cnt==0 check). A zero shift therefore completes at T+2.
  - Special and illegal codes: out_valid high at T+1.
- Width rules:
  - cnt is SHW bits.
  - out_val is exactly WIDTH bits; there is no rounding. Truncation is reported only through out_inexact.
- Inputs are sampled only at the accept edge; changes to in_* while busy are ignored.
- Round-trip property: for any nonzero v < 2048, normalising v to (n, s) and feeding (n, s, 0) must return v with inexact=0.

Test Plan:
- Numeric shift: in_val=12'h400, in_shift=3, in_zero=0, out_ready=1 -> out_val=12'h080, out_inexact=0, out_err=0; out_valid first high 5 edges after accept; in_ready high again the cycle after the handshake.
- Inexact: in_val=12'h5FF, in_shift=10 -> out_val=12'h001, out_inexact=1; in_val=12'h7FF, in_shift=0 -> out_val=12'h7FF, inexact=0, out_valid at T+2.
- Special codes: (12'h000, 31, zero=1) -> out_val=0 at T+1; (12'h9A3, 31, zero=0) -> out_val=12'h9A3, err=0.
- Illegal code: in_shift=15 -> out_val=0, out_err=1, out_valid at T+1. A following legal request clears err.
- Backpressure: hold out_ready=0 for 6 cycles in DONE -> out_valid/out_val stable, in_ready=0, and a new in_valid is not accepted; release -> single handshake, then IDLE.
- Reset mid-shift: accept in_shift=9, assert rst for 1 cycle after 4 shift cycles -> next cycle in_ready=1, out_valid=0, out_val=0. A new request (12'h400, 1) yields 12'h200 with no residue from the aborted one.
